// File: rtl/ship_ctl.sv
// ship_ctl: player ship position, lives and ALIVE/EXPLODE/RESPAWN/GAME_OVER control.
// Define SHIP_BLINK_EN to make the ship blink (frame counter bit 3) while respawning.
module ship_ctl #(
  parameter int XPOS_INIT      = 470,
  parameter int X_MIN          = 0,
  parameter int X_MAX          = 940,
  parameter int STEP           = 4,
  parameter int LIVES          = 3,
  parameter int EXPLODE_FRAMES = 60,
  parameter int INVULN_FRAMES  = 120
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        vsync_in,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        hit,
  input  logic        start,
  output logic [10:0] xpos,
  output logic        dead_ship,
  output logic [2:0]  lives,
  output logic        game_over,
  output logic        invuln
);
  localparam logic [10:0] P_INIT  = 11'(XPOS_INIT);
  localparam logic [10:0] P_MIN   = 11'(X_MIN);
  localparam logic [10:0] P_MAX   = 11'(X_MAX);
  localparam logic [10:0] P_STEP  = 11'(STEP);
  localparam logic [10:0] P_LO    = 11'(X_MIN + STEP);
  localparam logic [10:0] P_HI    = 11'(X_MAX - STEP);
  localparam logic [2:0]  P_LIVES = 3'(LIVES);
  localparam logic [7:0]  P_EX    = 8'(EXPLODE_FRAMES - 1);
  localparam logic [7:0]  P_IN    = 8'(INVULN_FRAMES - 1);

  typedef enum logic [1:0] {ALIVE, EXPLODE, RESPAWN, GAME_OVER} state_t;

  state_t      r_state, w_nxt;
  logic        r_vs, r_dead, r_gover, r_inv;
  logic [10:0] r_xpos, w_xpos, w_step;
  logic [2:0]  r_lives, w_lives;
  logic [7:0]  r_cnt, w_cnt;
  logic        w_tick, w_move, w_dead, w_gover, w_inv;

  assign w_tick    = vsync_in & ~r_vs;
  assign xpos      = r_xpos;
  assign dead_ship = r_dead;
  assign lives     = r_lives;
  assign game_over = r_gover;
  assign invuln    = r_inv;

  always_ff @(posedge pclk) begin
    if (rst) begin
      r_state <= ALIVE;
      r_vs    <= 1'b0;
      r_xpos  <= P_INIT;
      r_lives <= P_LIVES;
      r_cnt   <= '0;
      r_dead  <= 1'b0;
      r_gover <= 1'b0;
      r_inv   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_vs    <= vsync_in;
      r_xpos  <= w_xpos;
      r_lives <= w_lives;
      r_cnt   <= w_cnt;
      r_dead  <= w_dead;
      r_gover <= w_gover;
      r_inv   <= w_inv;
    end
  end

  always_comb begin
    w_nxt = (r_state == ALIVE && hit)                          ? EXPLODE :
            (r_state == EXPLODE && w_tick && r_cnt == P_EX)    ? (r_lives == 3'd0 ? GAME_OVER : RESPAWN) :
            (r_state == RESPAWN && w_tick && r_cnt == P_IN)    ? ALIVE :
            (r_state == GAME_OVER && start)                    ? ALIVE : r_state;
  end

  // saturation bounds are checked before stepping so xpos never wraps
  always_comb begin
    w_move  = w_tick && (r_state == RESPAWN || (r_state == ALIVE && !hit));
    w_step  = (btn_left && !btn_right) ? (r_xpos <= P_LO ? P_MIN : r_xpos - P_STEP) :
              (btn_right && !btn_left) ? (r_xpos >= P_HI ? P_MAX : r_xpos + P_STEP) : r_xpos;
    w_xpos  = ((r_state == EXPLODE && w_nxt == RESPAWN) || (r_state == GAME_OVER && start)) ? P_INIT :
              w_move ? w_step : r_xpos;
    w_lives = (r_state == GAME_OVER && start)                 ? P_LIVES :
              (r_state == ALIVE && hit && r_lives != 3'd0)    ? r_lives - 3'd1 : r_lives;
    w_cnt   = (w_nxt != r_state) ? '0 :
              (w_tick && (r_state == EXPLODE || r_state == RESPAWN)) ? r_cnt + 8'd1 : r_cnt;
  end

  // outputs follow the next state so they register alongside it
  always_comb begin
    w_gover = w_nxt == GAME_OVER;
    w_inv   = w_nxt == RESPAWN;
`ifdef SHIP_BLINK_EN
    w_dead  = w_nxt == EXPLODE || w_gover || (w_inv && w_cnt[3]);
`else
    w_dead  = w_nxt == EXPLODE || w_gover;
`endif
  end
endmodule

// File: tb/tb_ship_ctl.sv
// tb_ship_ctl: scoreboard bench for ship_ctl covering movement, saturation, hit/respawn, game over and reset.
module tb_ship_ctl;
  logic        pclk = 0, rst = 1, vsync_in = 0, btn_left = 0, btn_right = 0, hit = 0, start = 0;
  logic [10:0] xpos;
  logic        dead_ship, game_over, invuln;
  logic [2:0]  lives;
  int          checks = 0, errors = 0;

  typedef struct {string name; logic [16:0] v;} exp_t;
  exp_t sb[$];
  exp_t e;

  ship_ctl dut (
    .pclk(pclk), .rst(rst), .vsync_in(vsync_in), .btn_left(btn_left), .btn_right(btn_right),
    .hit(hit), .start(start), .xpos(xpos), .dead_ship(dead_ship), .lives(lives),
    .game_over(game_over), .invuln(invuln)
  );

  always #5 pclk = ~pclk;

  function automatic logic [16:0] pk(input int x, input bit d, input int l, input bit g, input bit v);
    return {11'(x), d, 3'(l), g, v};
  endfunction

  function automatic string fmt(input logic [16:0] v);
    return $sformatf("xpos=%0d dead=%b lives=%0d over=%b inv=%b", v[16:6], v[5], v[4:2], v[1], v[0]);
  endfunction

  function automatic logic [16:0] obs();
    return {xpos, dead_ship, lives, game_over, invuln};
  endfunction

  function automatic bit blink(input int k);
`ifdef SHIP_BLINK_EN
    return k[3];
`else
    return 1'b0;
`endif
  endfunction

  task automatic tick();
    @(negedge pclk) vsync_in = 1;
    @(negedge pclk) vsync_in = 0;
  endtask

  task automatic pulse_hit(input bit with_tick);
    @(negedge pclk) begin hit = 1; vsync_in = with_tick; end
    @(negedge pclk) begin hit = 0; vsync_in = 0; end
  endtask

  task automatic do_reset();
    @(negedge pclk) begin rst = 1; hit = 1; start = 1; end
    @(negedge pclk);
    @(negedge pclk) begin rst = 0; hit = 0; start = 0; end
  endtask

  task automatic test_reset();
    do_reset();
    sb.push_back('{"reset", pk(470, 0, 3, 0, 0)});
    e = sb.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %s, want %s", e.name, fmt(obs()), fmt(e.v)); end
    @(negedge pclk);
    sb.push_back('{"idle_hold", pk(470, 0, 3, 0, 0)});
    e = sb.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %s, want %s", e.name, fmt(obs()), fmt(e.v)); end
  endtask

  task automatic test_right();
    int x = 470;
    do_reset();
    btn_right = 1;
    for (int i = 0; i < 300; i++) begin
      x = (x >= 936) ? 940 : x + 4;
      sb.push_back('{$sformatf("right_%0d", i), pk(x, 0, 3, 0, 0)});
      tick();
      e = sb.pop_front(); checks++;
      if (obs() !== e.v) begin errors++; $display("FAIL %s: got %s, want %s", e.name, fmt(obs()), fmt(e.v)); end
    end
    btn_right = 0;
  endtask

  task automatic test_left();
    int x = 470;
    do_reset();
    btn_left = 1;
    for (int i = 0; i < 120; i++) begin
      x = (x <= 4) ? 0 : x - 4;
      sb.push_back('{$sformatf("left_%0d", i), pk(x, 0, 3, 0, 0)});
      tick();
      e = sb.pop_front(); checks++;
      if (obs() !== e.v) begin errors++; $display("FAIL %s: got %s, want %s", e.name, fmt(obs()), fmt(e.v)); end
    end
    btn_left = 0;
    btn_right = 1;
    repeat (2) tick();
    btn_left = 1;
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{$sformatf("both_%0d", i), pk(8, 0, 3, 0, 0)});
      tick();
      e = sb.pop_front(); checks++;
      if (obs() !== e.v) begin errors++; $display("FAIL %s: got %s, want %s", e.name, fmt(obs()), fmt(e.v)); end
    end
    btn_left = 0;
    btn_right = 0;
  endtask

  task automatic test_hit();
    do_reset();
    btn_right = 1;
    repeat (3) tick();
    sb.push_back('{"hit_alive", pk(482, 1, 2, 0, 0)});
    pulse_hit(0);
    e = sb.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %s, want %s", e.name, fmt(obs()), fmt(e.v)); end
    sb.push_back('{"start_ignored", pk(482, 1, 2, 0, 0)});
    @(negedge pclk) start = 1;
    @(negedge pclk) start = 0;
    e = sb.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %s, want %s", e.name, fmt(obs()), fmt(e.v)); end
    for (int i = 1; i <= 60; i++) begin
      sb.push_back('{$sformatf("explode_%0d", i), i < 60 ? pk(482, 1, 2, 0, 0) : pk(470, 0, 2, 0, 1)});
      tick();
      e = sb.pop_front(); checks++;
      if (obs() !== e.v) begin errors++; $display("FAIL %s: got %s, want %s", e.name, fmt(obs()), fmt(e.v)); end
    end
    btn_right = 0;
    sb.push_back('{"hit_respawn", pk(470, 0, 2, 0, 1)});
    pulse_hit(0);
    e = sb.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %s, want %s", e.name, fmt(obs()), fmt(e.v)); end
    for (int k = 1; k <= 120; k++) begin
      sb.push_back('{$sformatf("respawn_%0d", k), k < 120 ? pk(470, blink(k), 2, 0, 1) : pk(470, 0, 2, 0, 0)});
      tick();
      e = sb.pop_front(); checks++;
      if (obs() !== e.v) begin errors++; $display("FAIL %s: got %s, want %s", e.name, fmt(obs()), fmt(e.v)); end
    end
  endtask

  task automatic test_game_over();
    for (int h = 0; h < 2; h++) begin
      int l = 1 - h;
      int x = (h == 1) ? 462 : 470;
      if (h == 1) begin
        btn_left = 1;
        repeat (2) tick();
        btn_left = 0;
      end
      sb.push_back('{$sformatf("go_hit_%0d", h), pk(x, 1, l, 0, 0)});
      pulse_hit(0);
      e = sb.pop_front(); checks++;
      if (obs() !== e.v) begin errors++; $display("FAIL %s: got %s, want %s", e.name, fmt(obs()), fmt(e.v)); end
      repeat (59) tick();
      sb.push_back('{$sformatf("go_explode_end_%0d", h), l > 0 ? pk(470, 0, l, 0, 1) : pk(x, 1, 0, 1, 0)});
      tick();
      e = sb.pop_front(); checks++;
      if (obs() !== e.v) begin errors++; $display("FAIL %s: got %s, want %s", e.name, fmt(obs()), fmt(e.v)); end
      if (l > 0) begin
        repeat (119) tick();
        sb.push_back('{$sformatf("go_respawn_end_%0d", h), pk(470, 0, l, 0, 0)});
        tick();
        e = sb.pop_front(); checks++;
        if (obs() !== e.v) begin errors++; $display("FAIL %s: got %s, want %s", e.name, fmt(obs()), fmt(e.v)); end
      end
    end
    btn_right = 1;
    sb.push_back('{"over_ignores", pk(462, 1, 0, 1, 0)});
    pulse_hit(1);
    e = sb.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %s, want %s", e.name, fmt(obs()), fmt(e.v)); end
    btn_right = 0;
    sb.push_back('{"restart", pk(470, 0, 3, 0, 0)});
    @(negedge pclk) start = 1;
    @(negedge pclk) start = 0;
    e = sb.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %s, want %s", e.name, fmt(obs()), fmt(e.v)); end
  endtask

  task automatic test_hit_tick();
    do_reset();
    btn_right = 1;
    repeat (2) tick();
    sb.push_back('{"hit_wins", pk(478, 1, 2, 0, 0)});
    pulse_hit(1);
    e = sb.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %s, want %s", e.name, fmt(obs()), fmt(e.v)); end
    repeat (5) tick();
    sb.push_back('{"explode_frozen", pk(478, 1, 2, 0, 0)});
    e = sb.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %s, want %s", e.name, fmt(obs()), fmt(e.v)); end
    sb.push_back('{"rst_mid_explode", pk(470, 0, 3, 0, 0)});
    @(negedge pclk) begin rst = 1; hit = 1; start = 1; end
    @(negedge pclk) begin rst = 0; hit = 0; start = 0; end
    e = sb.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %s, want %s", e.name, fmt(obs()), fmt(e.v)); end
    btn_right = 0;
  endtask

  initial begin
    test_reset();
    test_right();
    test_left();
    test_hit();
    test_game_over();
    test_hit_tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
